charmquark1984_quad_tracker: RTL and testbench

Consumes the 2-bit Gray-coded phase produced by the stepping controller (sequence 00→01→11→10→00, one step per controller tick), tracks signed step position modulo POS_MAX+1, flags illegal phase jumps, and drives a 7-segment digit of the current position. Sits downstream of the controller; its phase input may come from off-chip, so it is treated as asynchronous.

---
 rtl/charmquark1984_pkg.sv | 60 ++++++
 rtl/charmquark1984_seg7.sv | 16 +
 rtl/charmquark1984_quad_tracker.sv | 128 ++++++++++++
 tb/tb_charmquark1984_quad_tracker.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/charmquark1984_pkg.sv
// Shared definitions for the quadrature phase tracker and the stepping controller:
// Gray phase codes, filter states, transition classes and the 7-segment encoder.
package charmquark1984_pkg;

   localparam logic [1:0] PH0 = 2'b00;
   localparam logic [1:0] PH1 = 2'b01;
   localparam logic [1:0] PH2 = 2'b11;
   localparam logic [1:0] PH3 = 2'b10;

   typedef enum logic {
      IDLE,
      QUALIFY
   } filt_state_t;

   typedef enum logic [1:0] {
      TR_NONE,
      TR_FWD,
      TR_REV,
      TR_ILLEGAL
   } trans_t;

   function automatic logic [1:0] next_fwd(input logic [1:0] p);
      case (p)
         PH0:     return PH1;
         PH1:     return PH2;
         PH2:     return PH3;
         default: return PH0;
      endcase
   endfunction

   function automatic trans_t classify(input logic [1:0] old_ph, input logic [1:0] new_ph);
      if (new_ph == old_ph)                return TR_NONE;
      else if (new_ph == next_fwd(old_ph)) return TR_FWD;
      else if (old_ph == next_fwd(new_ph)) return TR_REV;
      else                                 return TR_ILLEGAL;
   endfunction

   // Active-high segments, bit0=a ... bit6=g.
   function automatic logic [6:0] hex_to_seg7(input logic [3:0] v);
      case (v)
         4'h0:    return 7'h3F;
         4'h1:    return 7'h06;
         4'h2:    return 7'h5B;
         4'h3:    return 7'h4F;
         4'h4:    return 7'h66;
         4'h5:    return 7'h6D;
         4'h6:    return 7'h7D;
         4'h7:    return 7'h07;
         4'h8:    return 7'h7F;
         4'h9:    return 7'h6F;
         4'hA:    return 7'h77;
         4'hB:    return 7'h7C;
         4'hC:    return 7'h39;
         4'hD:    return 7'h5E;
         4'hE:    return 7'h79;
         default: return 7'h71;
      endcase
   endfunction

endpackage

// File: rtl/charmquark1984_seg7.sv
// Registered hex-to-7-segment driver; resets to the glyph for 0.
module charmquark1984_seg7
   import charmquark1984_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] value,
   output logic [6:0] segments
);

   always_ff @(posedge clk) begin
      if (reset) segments <= 7'h3F;
      else       segments <= hex_to_seg7(value);
   end

endmodule

// File: rtl/charmquark1984_quad_tracker.sv
// Tracks position from the controller's Gray phase: synchronizes, debounces,
// classifies each accepted transition and counts position modulo POS_MAX+1.
module charmquark1984_quad_tracker
   import charmquark1984_pkg::*;
#(
   parameter int FILTER_LEN = 3,
   parameter int POS_MAX    = 9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] phase_in,
   input  logic       clear,
   output logic [6:0] segments,
   output logic       step,
   output logic       dir,
   output logic       err
);

   localparam logic [3:0] FL   = 4'(FILTER_LEN);
   localparam logic [3:0] PMAX = 4'(POS_MAX);

   logic [1:0]  sync1, s;
   filt_state_t state;
   logic [1:0]  phase_q, cand;
   logic [3:0]  cnt, pos;
   logic        accept;
   logic [1:0]  acc_phase;
   trans_t      trans;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= PH0;
         s     <= PH0;
      end else begin
         sync1 <= phase_in;
         s     <= sync1;
      end
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      accept    = 1'b0;
      acc_phase = cand;
      case (state)
         IDLE: begin
            if (s != phase_q && FL == 4'd1) begin
               accept    = 1'b1;
               acc_phase = s;
            end
         end
         QUALIFY: begin
            // s == cand implies s != phase_q, so a return to phase_q never accepts.
            if (s == cand && (cnt + 4'd1) >= FL) accept = 1'b1;
         end
      endcase
   end

   assign trans = classify(phase_q, acc_phase);

   // NOTE: sequential state uses non-blocking assignments; the later clear
   // assignment therefore overrides a coincident step update of pos/err.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         phase_q <= PH0;
         cand    <= PH0;
         cnt     <= 4'd0;
         pos     <= 4'd0;
         step    <= 1'b0;
         dir     <= 1'b1;
         err     <= 1'b0;
      end else begin
         step <= 1'b0;
         case (state)
            IDLE: begin
               if (s != phase_q && !accept) begin
                  cand  <= s;
                  cnt   <= 4'd1;
                  state <= QUALIFY;
               end
            end
            QUALIFY: begin
               if (s == phase_q) begin
                  state <= IDLE;
               end else if (s != cand) begin
                  cand <= s;
                  cnt  <= 4'd1;
               end else if (accept) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
         endcase

         if (accept) begin
            phase_q <= acc_phase;
            case (trans)
               TR_FWD: begin
                  pos  <= (pos == PMAX) ? 4'd0 : pos + 4'd1;
                  dir  <= 1'b1;
                  step <= !clear;
               end
               TR_REV: begin
                  pos  <= (pos == 4'd0) ? PMAX : pos - 4'd1;
                  dir  <= 1'b0;
                  step <= !clear;
               end
               TR_ILLEGAL: err <= 1'b1;
               TR_NONE:    ;
            endcase
         end

         if (clear) begin
            pos <= 4'd0;
            err <= 1'b0;
         end
      end
   end

   charmquark1984_seg7 u_seg7 (
      .clk      (clk),
      .reset    (reset),
      .value    (pos),
      .segments (segments)
   );

endmodule

// File: tb/tb_charmquark1984_quad_tracker.sv
// Directed bench for the quadrature tracker (FILTER_LEN=3, POS_MAX=9) with
// hand-computed step timing, direction, error flag and segment glyphs.
module tb_charmquark1984_quad_tracker;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] phase_in;
   logic       clear;
   logic [6:0] segments;
   logic       step, dir, err;

   int vectors     = 0;
   int miscompares = 0;

   logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   logic [1:0] fwd_seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

   charmquark1984_quad_tracker #(.FILTER_LEN(3), .POS_MAX(9)) dut (
      .clk      (clk),
      .reset    (reset),
      .phase_in (phase_in),
      .clear    (clear),
      .segments (segments),
      .step     (step),
      .dir      (dir),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a new phase, expect the event exactly 4 edges after capture and the
   // segments one edge later, then dwell to 10 cycles total.
   task automatic move(input string tag, input logic [1:0] p, input logic exp_step,
                       input logic exp_dir, input logic exp_err, input logic [6:0] exp_seg);
      phase_in = p;
      for (int i = 0; i < 4; i++) begin
         tick();
         check({tag, "/early_step"}, step, 0);
      end
      tick();
      check({tag, "/step"}, step, exp_step);
      check({tag, "/dir"}, dir, exp_dir);
      check({tag, "/err"}, err, exp_err);
      tick();
      check({tag, "/step_off"}, step, 0);
      check({tag, "/seg"}, segments, exp_seg);
      repeat (4) tick();
   endtask

   task automatic do_clear(input string tag);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check({tag, "/err"}, err, 0);
      tick();
      check({tag, "/seg"}, segments, 7'h3F);
   endtask

   initial begin
      reset    = 1'b1;
      phase_in = 2'b00;
      clear    = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      tick();
      check("rst/seg", segments, 7'h3F);
      check("rst/step", step, 0);
      check("rst/dir", dir, 1);
      check("rst/err", err, 0);

      // One full forward cycle: pos 1..4.
      move("fwd1", 2'b01, 1, 1, 0, 7'h06);
      move("fwd2", 2'b11, 1, 1, 0, 7'h5B);
      move("fwd3", 2'b10, 1, 1, 0, 7'h4F);
      move("fwd4", 2'b00, 1, 1, 0, 7'h66);

      // Reverse wrap 0 -> 9, forward wrap 9 -> 0, then ten forward steps.
      do_clear("clr1");
      move("rev_wrap", 2'b10, 1, 0, 0, 7'h6F);
      move("fwd_wrap", 2'b00, 1, 1, 0, 7'h3F);
      for (int i = 0; i < 10; i++)
         move($sformatf("ten%0d", i), fwd_seq[i % 4], 1, 1, 0, seg_tbl[(i + 1) % 10]);

      // Phase now 11, pos 0.
      move("to10", 2'b10, 1, 1, 0, 7'h06);
      move("to00", 2'b00, 1, 1, 0, 7'h5B);
      move("illegal", 2'b11, 0, 1, 1, 7'h5B);
      move("after_ill", 2'b10, 1, 1, 1, 7'h4F);
      do_clear("clr2");

      // Two-cycle glitch 10 -> 00 -> 10 must be rejected.
      phase_in = 2'b00;
      repeat (2) tick();
      phase_in = 2'b10;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("glitch/step", step, 0);
      end
      move("post_glitch", 2'b00, 1, 1, 0, 7'h06);
      move("to01", 2'b01, 1, 1, 0, 7'h5B);

      // Flicker 11,11,10 then settle on 11: single accept timed from last change.
      phase_in = 2'b11;
      repeat (2) begin
         tick();
         check("flicker/step", step, 0);
      end
      phase_in = 2'b10;
      tick();
      check("flicker/step", step, 0);
      move("flicker_settle", 2'b11, 1, 1, 0, 7'h4F);

      // Reverse to 01 (dir=0), then clear coincident with the 01 -> 11 accept.
      move("rev_to01", 2'b01, 1, 0, 0, 7'h5B);
      phase_in = 2'b11;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("clracc/early_step", step, 0);
      end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check("clracc/step", step, 0);
      check("clracc/dir", dir, 1);
      check("clracc/err", err, 0);
      tick();
      check("clracc/seg", segments, 7'h3F);
      repeat (4) tick();
      move("after_clracc", 2'b10, 1, 1, 0, 7'h06);

      // Build non-reset state: pos 9, dir 0, err 1, phase 10.
      move("rev_a", 2'b11, 1, 0, 0, 7'h3F);
      move("rev_b", 2'b01, 1, 0, 0, 7'h6F);
      move("ill_b", 2'b10, 0, 0, 1, 7'h6F);

      // Reset while qualifying 10 -> 00.
      phase_in = 2'b00;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      check("midrst/seg", segments, 7'h3F);
      check("midrst/step", step, 0);
      check("midrst/dir", dir, 1);
      check("midrst/err", err, 0);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("midrst/no_step", step, 0);
      end
      move("post_rst", 2'b01, 1, 1, 0, 7'h06);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
